// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM loader.
package pwm_pkg;

    localparam logic [10:0] ADDR_PIXMAP  = 11'h000;
    localparam logic [10:0] ADDR_TABLE   = 11'h400;
    localparam logic [10:0] ADDR_ENABLE  = 11'h755;
    localparam logic [15:0] ENABLE_MAGIC = 16'h0023;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        TABLE  = 2'd2,
        ENABLE = 2'd3
    } load_state_t;

endpackage

// File: rtl/pwm_ramp_gen.sv
// Saturating linear ramp: value = base + n*step, pinned at 0xFFFF once it overflows.
module pwm_ramp_gen
    import pwm_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [15:0] base,
    input  logic [15:0] step,
    output logic [15:0] value
);

    logic [16:0] acc;
    logic [15:0] step_q;

    // Once bit 16 is set the accumulator stops, so the saturated value holds.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            acc    <= '0;
            step_q <= '0;
        end else if (load) begin
            acc    <= {1'b0, base};
            step_q <= step;
        end else if (advance && !acc[16]) begin
            acc <= acc + {1'b0, step_q};
        end
    end

    assign value = acc[16] ? 16'hFFFF : acc[15:0];

endmodule

// File: rtl/pwm_loader.sv
// Sequences pixmap clear, pwmtable fill and the enable write onto the PWM write port,
// sharing the port with host writes when idle.
//
// state  | meaning
// IDLE   | waiting for start; host writes forwarded
// CLEAR  | writing zeros to the pixmap, one word per cycle
// TABLE  | writing ramp values to the pwmtable
// ENABLE | writing the enable magic, then back to IDLE
module pwm_loader
    import pwm_pkg::*;
#(
    parameter int CLR_WORDS = 1024,
    parameter int TBL_WORDS = 256
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clr_en,
    input  logic [15:0] base,
    input  logic [15:0] step,
    input  logic        host_we,
    input  logic [10:0] host_addr,
    input  logic [15:0] host_din,
    output logic        host_ack,
    output logic        busy,
    output logic        done,
    output logic        pwm_we,
    output logic [10:0] pwm_addr,
    output logic [15:0] pwm_din
);

    localparam logic [10:0] CLR_LAST = 11'(CLR_WORDS - 1);
    localparam logic [10:0] TBL_LAST = 11'(TBL_WORDS - 1);

    load_state_t state;
    logic [10:0] idx;
    logic [15:0] ramp_value;
    logic        ramp_load;
    logic        ramp_advance;

    assign host_ack     = host_we & (state == IDLE) & ~start & ~reset;
    assign ramp_load    = (state == IDLE) & start;
    assign ramp_advance = (state == TABLE);

    pwm_ramp_gen u_ramp (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .load    (ramp_load),
        .advance (ramp_advance),
        .base    (base),
        .step    (step),
        .value   (ramp_value)
    );

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pwm_we   <= 1'b0;
            pwm_addr <= '0;
            pwm_din  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (start) begin
                        state  <= clr_en ? CLEAR : TABLE;
                        busy   <= 1'b1;
                        pwm_we <= 1'b0;
                    end else if (host_ack) begin
                        pwm_we   <= 1'b1;
                        pwm_addr <= host_addr;
                        pwm_din  <= host_din;
                    end else begin
                        pwm_we <= 1'b0;
                    end
                end
                CLEAR: begin
                    pwm_we   <= 1'b1;
                    pwm_addr <= ADDR_PIXMAP + idx;
                    pwm_din  <= 16'h0000;
                    if (idx == CLR_LAST) begin
                        state <= TABLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 11'd1;
                    end
                end
                TABLE: begin
                    pwm_we   <= 1'b1;
                    pwm_addr <= ADDR_TABLE + idx;
                    pwm_din  <= ramp_value;
                    if (idx == TBL_LAST) begin
                        state <= ENABLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 11'd1;
                    end
                end
                ENABLE: begin
                    pwm_we   <= 1'b1;
                    pwm_addr <= ADDR_ENABLE;
                    pwm_din  <= ENABLE_MAGIC;
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_loader.sv
// Directed bench for pwm_loader: write sequences, saturation, host arbitration, reset abort.
module tb_pwm_loader;

    localparam int CLR_WORDS = 1024;
    localparam int TBL_WORDS = 256;

    logic        cpu_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic        clr_en  = 1'b0;
    logic [15:0] base    = '0;
    logic [15:0] step    = '0;
    logic        host_we = 1'b0;
    logic [10:0] host_addr = '0;
    logic [15:0] host_din  = '0;
    logic        host_ack, busy, done, pwm_we;
    logic [10:0] pwm_addr;
    logic [15:0] pwm_din;

    int n_assert = 0;
    int n_fail   = 0;

    pwm_loader #(.CLR_WORDS(CLR_WORDS), .TBL_WORDS(TBL_WORDS)) dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .start     (start),
        .clr_en    (clr_en),
        .base      (base),
        .step      (step),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_ack  (host_ack),
        .busy      (busy),
        .done      (done),
        .pwm_we    (pwm_we),
        .pwm_addr  (pwm_addr),
        .pwm_din   (pwm_din)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Runs one sequence from the current negedge; returns at the negedge where done is seen.
    task automatic run_sequence(input logic clr, input logic [15:0] b, input logic [15:0] s,
                                input int host_at, input int restart_at,
                                output int busy_cyc, output int nwr, output logic [15:0] first_d,
                                output logic [10:0] last_tbl_a, output logic [15:0] last_tbl_d,
                                output logic [10:0] last_a, output logic [15:0] last_d);
        int c, t, v, cyc;
        logic [10:0] ea;
        logic [15:0] ed;
        bit fin;
        c = clr ? CLR_WORDS : 0;
        busy_cyc = 0; nwr = 0; fin = 0;
        first_d = 'x; last_tbl_a = 'x; last_tbl_d = 'x; last_a = 'x; last_d = 'x;
        start = 1'b1; clr_en = clr; base = b; step = s;
        if (host_at == 0) begin
            host_we = 1'b1; host_addr = 11'h123; host_din = 16'h00AB;
            #1;
            n_assert++;
            if (host_ack !== 1'b0) begin n_fail++; $display("FAIL ack_with_start: got %b expected 0", host_ack); end
        end
        @(negedge cpu_clk);
        start = 1'b0; base = 16'hDEAD; step = 16'h7777;
        cyc = 1;
        while (!fin && cyc < 4000) begin
            if (busy) busy_cyc++;
            if (host_we && busy) begin
                n_assert++;
                if (host_ack !== 1'b0) begin n_fail++; $display("FAIL ack_while_busy: got %b expected 0 at cycle %0d", host_ack, cyc); end
            end
            if (pwm_we) begin
                if (nwr < c) begin
                    ea = 11'(nwr); ed = 16'h0000;
                end else begin
                    t = nwr - c;
                    if (t < TBL_WORDS) begin
                        v = int'(b) + t * int'(s);
                        ea = 11'h400 + 11'(t);
                        ed = (v > 32'h0000FFFF) ? 16'hFFFF : v[15:0];
                        if (t == 0) first_d = pwm_din;
                        if (t == TBL_WORDS - 1) begin last_tbl_a = pwm_addr; last_tbl_d = pwm_din; end
                    end else begin
                        ea = 11'h755; ed = 16'h0023;
                    end
                end
                n_assert++;
                if (pwm_addr !== ea || pwm_din !== ed) begin
                    n_fail++;
                    $display("FAIL write[%0d]: got %h/%h expected %h/%h", nwr, pwm_addr, pwm_din, ea, ed);
                end
                last_a = pwm_addr; last_d = pwm_din;
                nwr++;
            end
            if (done) begin
                fin = 1;
                n_assert++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_with_done: got %b expected 0", busy); end
            end
            if (!fin) begin
                if (cyc == host_at) begin host_we = 1'b1; host_addr = 11'h123; host_din = 16'h00AB; end
                if (cyc == restart_at) begin start = 1'b1; base = 16'h1111; step = 16'h2222; clr_en = 1'b1; end
                else start = 1'b0;
                @(negedge cpu_clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) begin n_assert++; n_fail++; $display("FAIL seq_timeout: got no done expected done within 4000 cycles"); end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge cpu_clk);
        host_we = 1'b1; host_addr = 11'h001; host_din = 16'h5555;
        #1;
        n_assert++;
        if (host_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", host_ack); end
        n_assert++;
        if ({busy, done, pwm_we, pwm_addr, pwm_din} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b addr=%h din=%h expected all 0", busy, done, pwm_we, pwm_addr, pwm_din);
        end
        host_we = 1'b0;
        @(negedge cpu_clk);
        reset = 1'b0;
        @(negedge cpu_clk);
    endtask

    task automatic test_table_only;
        int bc, nw; logic [15:0] fd, ltd, ld; logic [10:0] lta, la;
        run_sequence(1'b0, 16'h0010, 16'h0004, -1, 20, bc, nw, fd, lta, ltd, la, ld);
        n_assert++;
        if (bc !== 257) begin n_fail++; $display("FAIL tbl_busy_cycles: got %0d expected 257", bc); end
        n_assert++;
        if (nw !== 257) begin n_fail++; $display("FAIL tbl_write_count: got %0d expected 257", nw); end
        n_assert++;
        if (fd !== 16'h0010) begin n_fail++; $display("FAIL tbl_first_data: got %h expected 0010", fd); end
        n_assert++;
        if (lta !== 11'h4FF || ltd !== 16'h040C) begin n_fail++; $display("FAIL tbl_last_entry: got %h/%h expected 4ff/040c", lta, ltd); end
        n_assert++;
        if (la !== 11'h755 || ld !== 16'h0023) begin n_fail++; $display("FAIL tbl_enable: got %h/%h expected 755/0023", la, ld); end
        @(negedge cpu_clk);
        n_assert++;
        if (pwm_we !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL tbl_after_done: got we=%b done=%b expected 0/0", pwm_we, done); end
    endtask

    task automatic test_clear;
        int bc, nw; logic [15:0] fd, ltd, ld; logic [10:0] lta, la;
        run_sequence(1'b1, 16'h0100, 16'h0001, -1, -1, bc, nw, fd, lta, ltd, la, ld);
        n_assert++;
        if (bc !== 1281) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d expected 1281", bc); end
        n_assert++;
        if (nw !== 1281) begin n_fail++; $display("FAIL clr_write_count: got %0d expected 1281", nw); end
        n_assert++;
        if (lta !== 11'h4FF || ltd !== 16'h01FF) begin n_fail++; $display("FAIL clr_last_entry: got %h/%h expected 4ff/01ff", lta, ltd); end
        @(negedge cpu_clk);
    endtask

    task automatic test_saturate;
        int bc, nw; logic [15:0] fd, ltd, ld; logic [10:0] lta, la;
        run_sequence(1'b0, 16'hFF00, 16'h0100, -1, -1, bc, nw, fd, lta, ltd, la, ld);
        n_assert++;
        if (fd !== 16'hFF00) begin n_fail++; $display("FAIL sat_first: got %h expected ff00", fd); end
        n_assert++;
        if (ltd !== 16'hFFFF) begin n_fail++; $display("FAIL sat_last: got %h expected ffff", ltd); end
        n_assert++;
        if (nw !== 257) begin n_fail++; $display("FAIL sat_write_count: got %0d expected 257", nw); end
        @(negedge cpu_clk);
    endtask

    // Host write held from host_at onward; it must land exactly once, right after done.
    task automatic test_host(input int host_at, input string tag);
        int bc, nw, hits; logic [15:0] fd, ltd, ld; logic [10:0] lta, la;
        run_sequence(1'b0, 16'h0000, 16'h0001, host_at, -1, bc, nw, fd, lta, ltd, la, ld);
        n_assert++;
        if (nw !== 257 || la !== 11'h755) begin n_fail++; $display("FAIL %s_seq: got %0d writes last %h expected 257 writes last 755", tag, nw, la); end
        n_assert++;
        if (host_ack !== 1'b1) begin n_fail++; $display("FAIL %s_ack_at_idle: got %b expected 1", tag, host_ack); end
        @(negedge cpu_clk);
        n_assert++;
        if (pwm_we !== 1'b1 || pwm_addr !== 11'h123 || pwm_din !== 16'h00AB) begin
            n_fail++; $display("FAIL %s_host_write: got %b %h/%h expected 1 123/00ab", tag, pwm_we, pwm_addr, pwm_din);
        end
        host_we = 1'b0;
        hits = 0;
        repeat (4) begin
            @(negedge cpu_clk);
            if (pwm_we) hits++;
        end
        n_assert++;
        if (hits !== 0) begin n_fail++; $display("FAIL %s_extra_writes: got %0d expected 0", tag, hits); end
        n_assert++;
        if (pwm_addr !== 11'h123 || pwm_din !== 16'h00AB) begin n_fail++; $display("FAIL %s_hold: got %h/%h expected 123/00ab", tag, pwm_addr, pwm_din); end
    endtask

    task automatic test_reset_abort;
        int bc, nw, n755, k; logic [15:0] fd, ltd, ld; logic [10:0] lta, la;
        bit seen;
        start = 1'b1; clr_en = 1'b0; base = 16'h0002; step = 16'h0003;
        @(negedge cpu_clk);
        start = 1'b0;
        seen = 0;
        for (k = 0; k < 400 && !seen; k++) begin
            if (pwm_we && pwm_addr == 11'h464) seen = 1;
            else @(negedge cpu_clk);
        end
        n_assert++;
        if (!seen) begin n_fail++; $display("FAIL abort_reach_idx100: got none expected write to 464"); end
        reset = 1'b1;
        host_we = 1'b1; host_addr = 11'h0AA; host_din = 16'h1234;
        @(negedge cpu_clk);
        n_assert++;
        if ({busy, done, pwm_we, pwm_addr, pwm_din} !== 30'd0) begin
            n_fail++; $display("FAIL abort_outputs: got busy=%b done=%b we=%b addr=%h din=%h expected all 0", busy, done, pwm_we, pwm_addr, pwm_din);
        end
        n_assert++;
        if (host_ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack_in_reset: got %b expected 0", host_ack); end
        host_we = 1'b0;
        reset = 1'b0;
        n755 = 0;
        repeat (6) begin
            @(negedge cpu_clk);
            if (pwm_we) n755++;
        end
        n_assert++;
        if (n755 !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: got %0d writes busy=%b expected 0/0", n755, busy); end
        run_sequence(1'b0, 16'h0010, 16'h0004, -1, -1, bc, nw, fd, lta, ltd, la, ld);
        n_assert++;
        if (bc !== 257 || nw !== 257 || ltd !== 16'h040C) begin
            n_fail++; $display("FAIL abort_rerun: got busy=%0d writes=%0d last=%h expected 257/257/040c", bc, nw, ltd);
        end
        @(negedge cpu_clk);
    endtask

    initial begin
        test_reset();
        test_table_only();
        test_clear();
        test_saturate();
        test_host(5, "host_stall");
        test_host(0, "host_collide");
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_loader.md
PWM_LOADER -- requirements
Module: pwm_loader

Interface
REQ-001 SHALL have parameter CLR_WORDS, default 1024, the number of pixmap words cleared by a clear pass.
REQ-002 SHALL have parameter TBL_WORDS, default 256, the number of pwmtable entries written per load.
REQ-003 cpu_clk  in  1  single clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse that starts a load sequence.
REQ-006 clr_en  in  1  sampled with start; when 1, the pixmap is cleared first.
REQ-007 base  in  16  first pwmtable delay value; sampled with start.
REQ-008 step  in  16  delay increment per table index; sampled with start.
REQ-009 host_we  in  1  host write request; held until acknowledged.
REQ-010 host_addr  in  11  host word address.
REQ-011 host_din  in  16  host write data.
REQ-012 host_ack  out  1  combinational; the host write is accepted this cycle.
REQ-013 busy  out  1  high while the sequence is not in IDLE.
REQ-014 done  out  1  one-cycle pulse when a sequence completes.
REQ-015 pwm_we  out  1  registered write strobe to the PWM write port.
REQ-016 pwm_addr  out  11  registered write address.
REQ-017 pwm_din  out  16  registered write data.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, TABLE and ENABLE.
REQ-019 Transitions: IDLE->CLEAR on start&clr_en; IDLE->TABLE on start&~clr_en; CLEAR->TABLE after write CLR_WORDS-1; TABLE->ENABLE after write TBL_WORDS-1; ENABLE->IDLE after one cycle.
REQ-020 start outside IDLE SHALL be ignored; base and step SHALL NOT be resampled.
REQ-021 CLEAR SHALL issue one write per cycle: addr 0x000..CLR_WORDS-1 ascending, data 0x0000.
REQ-022 TABLE SHALL issue one write per cycle: addr 0x400+i for i=0..TBL_WORDS-1, data = base + i*step.
REQ-023 Table data SHALL be formed by a 17-bit accumulator, not a multiplier.
REQ-024 When the accumulator carries out, the value SHALL saturate to 0xFFFF and hold for all remaining entries.
REQ-025 ENABLE SHALL issue exactly one write: addr 0x755, data 0x0023 (the enable magic); it is always the last write of the sequence.
REQ-026 done SHALL pulse in the cycle in which ENABLE->IDLE occurs.
REQ-027 busy SHALL rise the cycle after start is accepted and fall together with the done pulse.
REQ-028 host_ack = host_we & (state==IDLE) & ~start.
REQ-029 An acknowledged host write in cycle N SHALL appear on pwm_we/addr/din in cycle N+1.
REQ-030 Loader writes have absolute priority; host_we SHALL stall with no ack while busy, with no data loss.
REQ-031 If start and host_we coincide in IDLE, start SHALL win and the host write SHALL stall.
REQ-032 pwm_we SHALL be high only for a loader write or an acknowledged host write.
REQ-033 pwm_addr/pwm_din SHALL hold their last values when pwm_we is low.
REQ-034 The sequence SHALL be gap-free: busy cycles = (clr_en?CLR_WORDS:0) + TBL_WORDS + 1.

Reset
REQ-035 Reset SHALL force state IDLE, busy=0, done=0, pwm_we=0, pwm_addr=0, pwm_din=0, counters=0 and the accumulator=0.
REQ-036 Reset mid-sequence SHALL abort without the enable write; the pwm_we of the reset cycle+1 SHALL be 0.
REQ-037 The outputs of a reset cycle SHALL be driven as reset values; host_ack SHALL be 0 while reset=1.

Structure
REQ-038 Package pwm_pkg SHALL hold ADDR_PIXMAP=0x000, ADDR_TABLE=0x400, ADDR_ENABLE=0x755, ENABLE_MAGIC=0x0023 and the FSM state typedef.
REQ-039 The saturating accumulator SHALL be a sub-module pwm_ramp_gen (inputs load, base, step, advance; output value).

Verification
REQ-040 Test: start, clr_en=0, base=0x0010, step=0x0004 -> 257 writes; addr 0x400 data 0x0010, addr 0x4FF data 0x040C, then 0x755/0x0023; done after 257 busy cycles.
REQ-041 Test: start, clr_en=1 -> writes of 0x0000 to 0x000..0x3FF, then table, then enable; total 1281 busy cycles.
REQ-042 Test: base=0xFF00, step=0x0100 -> entry 0 is 0xFF00; entries 1..255 are 0xFFFF.
REQ-043 Test: host_we held at 0x123 with data 0x00AB during busy -> no ack until IDLE; exactly one pwm_we with 0x123/0x00AB, one cycle after ack.
REQ-044 Test: start and host_we in the same cycle -> the sequence runs first; the host write lands after done.
REQ-045 Test: reset asserted at table index 100 -> pwm_we=0 from the next cycle; no 0x755 write; busy=0; a new start runs the full sequence.
